// File: rtl/fmul_fract_mult_seq.sv
// Sequential shift-add 24x24 fraction multiplier for the FMUL path, STEP_BITS multiplier bits per cycle.
// Define FMUL_MULT_ZERO_SKIP_EN to bypass the iterations when either operand is zero.
module fmul_fract_mult_seq #(
   parameter int unsigned STEP_BITS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] fracta,
   input  logic [23:0] fractb,
   input  logic        sign_in,
   input  logic [7:0]  exp_in,
   output logic        busy,
   output logic        done,
   output logic [47:0] prod,
   output logic        sign_out,
   output logic [7:0]  exp_out
);

   localparam int unsigned N    = 24 / STEP_BITS;
   localparam logic [4:0]  LAST = 5'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] mcand_q, mcand_d;
   logic [23:0] mplier_q, mplier_d;
   logic [47:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [47:0] prod_q, prod_d;
   logic        sign_out_q, sign_out_d;
   logic [7:0]  exp_out_q, exp_out_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic [47:0] pp;
   logic [47:0] pp_shift;
   logic [47:0] acc_next;
   logic [5:0]  shamt;

   // Partial product of the current multiplier digit, aligned to its weight.
   always_comb begin
      pp       = 48'(mcand_q) * 48'(mplier_q[STEP_BITS-1:0]);
      shamt    = 6'(STEP_BITS * 32'(cnt_q));
      pp_shift = pp << shamt;
      acc_next = acc_q + pp_shift;
   end

   assign accept = start && (state_q != S_RUN);

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      prod_d     = prod_q;
      sign_out_d = sign_out_q;
      exp_out_d  = exp_out_q;

      case (state_q)
         S_RUN: begin
            acc_d    = acc_next;
            mplier_d = mplier_q >> STEP_BITS;
            cnt_d    = 5'(cnt_q + 5'd1);
            if (cnt_q == LAST) begin
               state_d    = S_DONE;
               prod_d     = acc_next;
               sign_out_d = sign_q;
               exp_out_d  = exp_q;
            end
         end
         default: begin
            if (accept) begin
               mcand_d  = fracta;
               mplier_d = fractb;
               acc_d    = '0;
               cnt_d    = '0;
               sign_d   = sign_in;
               exp_d    = exp_in;
               state_d  = S_RUN;
`ifdef FMUL_MULT_ZERO_SKIP_EN
               // A zero operand makes the product trivially zero; publish it right away.
               if ((fracta == '0) || (fractb == '0)) begin
                  state_d    = S_DONE;
                  prod_d     = '0;
                  sign_out_d = sign_in;
                  exp_out_d  = exp_in;
               end
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         prod_q     <= '0;
         sign_out_q <= 1'b0;
         exp_out_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         prod_q     <= prod_d;
         sign_out_q <= sign_out_d;
         exp_out_q  <= exp_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign prod     = prod_q;
   assign sign_out = sign_out_q;
   assign exp_out  = exp_out_q;

endmodule

// File: tb/tb_fmul_fract_mult_seq.sv
// Self-checking bench for fmul_fract_mult_seq: vector table, corner-case sequences and random run.
module tb_fmul_fract_mult_seq;

   localparam int unsigned STEP = 2;
   localparam int unsigned N    = 24 / STEP;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] fracta;
   logic [23:0] fractb;
   logic        sign_in;
   logic [7:0]  exp_in;
   logic        busy;
   logic        done;
   logic [47:0] prod;
   logic        sign_out;
   logic [7:0]  exp_out;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   fmul_fract_mult_seq #(.STEP_BITS(STEP)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .fracta   (fracta),
      .fractb   (fractb),
      .sign_in  (sign_in),
      .exp_in   (exp_in),
      .busy     (busy),
      .done     (done),
      .prod     (prod),
      .sign_out (sign_out),
      .exp_out  (exp_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic        s;
      logic [7:0]  e;
      logic [47:0] p;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Expected edge count from accept to done: N, or none when a zero operand is short-circuited.
   function automatic int unsigned ref_latency(input logic [23:0] a, input logic [23:0] b);
      int unsigned l;
      l = N;
`ifdef FMUL_MULT_ZERO_SKIP_EN
      if (a == 24'd0 || b == 24'd0) l = 0;
`endif
      return l;
   endfunction

   task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic s,
                         input logic [7:0] e, input logic [47:0] ref_p, input logic full,
                         input string tag);
      int unsigned ref_lat;
      int unsigned lat;
      logic        busy0;
      ref_lat = ref_latency(a, b);
      fracta  = a;
      fractb  = b;
      sign_in = s;
      exp_in  = e;
      start   = 1'b1;
      tick();
      start = 1'b0;
      busy0 = busy;
      lat   = 0;
      while (!done && lat < N + 4) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(ref_lat));
      check({tag, " prod"}, 64'(prod), 64'(ref_p));
      check({tag, " sign_out"}, 64'(sign_out), 64'(s));
      check({tag, " exp_out"}, 64'(exp_out), 64'(e));
      if (full) begin
         check({tag, " busy after accept"}, 64'(busy0), (ref_lat == 0) ? 64'd0 : 64'd1);
         check({tag, " busy at done"}, 64'(busy), 64'd0);
         tick();
         check({tag, " done pulse width"}, 64'(done), 64'd0);
      end
   endtask

   vec_t vecs[7];

   initial begin
      int unsigned ndone;
      int unsigned dlat;
      logic [47:0] dprod;
      logic [23:0] ra;
      logic [23:0] rb;
      logic        rs;
      logic [7:0]  re;

      vecs[0] = '{a: 24'h800000, b: 24'h800000, s: 1'b1, e: 8'h7F, p: 48'h400000000000};
      vecs[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, s: 1'b0, e: 8'h80, p: 48'hFFFFFE000001};
      vecs[2] = '{a: 24'hC00000, b: 24'hA00000, s: 1'b1, e: 8'h01, p: 48'h780000000000};
      vecs[3] = '{a: 24'h000000, b: 24'h912345, s: 1'b1, e: 8'h55, p: 48'h000000000000};
      vecs[4] = '{a: 24'h000001, b: 24'h7FFFFF, s: 1'b0, e: 8'h00, p: 48'h0000007FFFFF};
      vecs[5] = '{a: 24'h800000, b: 24'hFFFFFF, s: 1'b0, e: 8'hFE, p: 48'h7FFFFF800000};
      vecs[6] = '{a: 24'h123456, b: 24'h000002, s: 1'b1, e: 8'hAA, p: 48'h0000002468AC};

      reset   = 1'b1;
      start   = 1'b1;
      fracta  = 24'hFFFFFF;
      fractb  = 24'hFFFFFF;
      sign_in = 1'b1;
      exp_in  = 8'hFF;
      repeat (3) tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset prod", 64'(prod), 64'd0);
      check("reset sign_out", 64'(sign_out), 64'd0);
      check("reset exp_out", 64'(exp_out), 64'd0);
      start = 1'b0;
      reset = 1'b0;
      tick();
      check("idle busy", 64'(busy), 64'd0);

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, vecs[i].p, 1'b1,
                $sformatf("vec%0d", i));

      // Start pulsed again at E5 while running must be ignored.
      fracta  = 24'hC00000;
      fractb  = 24'hA00000;
      sign_in = 1'b0;
      exp_in  = 8'h33;
      start   = 1'b1;
      tick();
      ndone = 0;
      dlat  = 0;
      dprod = '0;
      for (int unsigned lat = 1; lat <= N + 4; lat++) begin
         start  = (lat == 5);
         fracta = (lat == 5) ? 24'hFFFFFF : 24'hC00000;
         fractb = (lat == 5) ? 24'h123456 : 24'hA00000;
         tick();
         if (done) begin
            ndone++;
            dlat  = lat;
            dprod = prod;
         end
      end
      start = 1'b0;
      check("ignored start done count", 64'(ndone), 64'd1);
      check("ignored start latency", 64'(dlat), 64'(N));
      check("ignored start prod", 64'(dprod), 64'h780000000000);

      // Back-to-back with start held through DONE.
      fracta  = 24'h800000;
      fractb  = 24'hFFFFFF;
      sign_in = 1'b1;
      exp_in  = 8'h10;
      start   = 1'b1;
      tick();
      dlat = 0;
      while (!done && dlat < N + 4) begin
         tick();
         dlat++;
      end
      check("b2b first latency", 64'(dlat), 64'(N));
      check("b2b first prod", 64'(prod), 64'h7FFFFF800000);
      fracta  = 24'hC00000;
      fractb  = 24'hA00000;
      sign_in = 1'b0;
      exp_in  = 8'h20;
      tick();
      start = 1'b0;
      check("b2b done dropped", 64'(done), 64'd0);
      check("b2b second busy", 64'(busy), 64'd1);
      dlat = 0;
      while (!done && dlat < N + 4) begin
         tick();
         dlat++;
      end
      check("b2b second latency", 64'(dlat), 64'(N));
      check("b2b second prod", 64'(prod), 64'h780000000000);
      check("b2b second exp", 64'(exp_out), 64'h20);
      tick();

      // Reset at E6 abandons the operation.
      fracta  = 24'hFFFFFF;
      fractb  = 24'hFFFFFF;
      sign_in = 1'b1;
      exp_in  = 8'h7F;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrun reset outputs", 64'({busy, done, sign_out, exp_out}), 64'd0);
      check("midrun reset prod", 64'(prod), 64'd0);
      ndone = 0;
      for (int unsigned k = 0; k < N + 4; k++) begin
         tick();
         if (done) ndone++;
      end
      check("midrun reset no done", 64'(ndone), 64'd0);
      run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 8'h7F, 48'hFFFFFE000001, 1'b1, "after reset");

      // Random operands against plain multiplication.
      for (int i = 0; i < 1500; i++) begin
         ra = 24'($urandom);
         rb = 24'($urandom);
         if ($urandom_range(0, 15) == 0) ra = '0;
         if ($urandom_range(0, 15) == 0) rb = '0;
         if ($urandom_range(0, 15) == 0) ra = 24'hFFFFFF;
         rs = 1'($urandom);
         re = 8'($urandom);
         run_op(ra, rb, rs, re, 48'(ra) * 48'(rb), 1'($urandom_range(0, 3) == 0),
                $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
